// File: rtl/redmule_mx_input_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : redmule_mx_input_stage
// Brief    : Splits packed MX memory beats into MX blocks paired with shared
//            exponents, or passes non-MX beats straight through.
// Options  : REDMULE_MX_EXP_FIFO_EN - 4-deep exponent FIFO instead of a
//            single exponent register.
// Revision : 1.0 - initial release
// ============================================================================
module redmule_mx_input_stage #(
  parameter int unsigned DATAW_ALIGN = 512,
  parameter int unsigned MX_BLOCK_W  = 256,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     mx_enable_i,

  input  logic                     beat_valid_i,
  output logic                     beat_ready_o,
  input  logic [DATAW_ALIGN-1:0]   beat_data_i,
  input  logic [DATAW_ALIGN/8-1:0] beat_strb_i,

  input  logic                     exp_valid_i,
  output logic                     exp_ready_o,
  input  logic [DATAW_ALIGN-1:0]   exp_data_i,

  output logic                     blk_valid_o,
  input  logic                     blk_ready_i,
  output logic [MX_BLOCK_W-1:0]    blk_data_o,
  output logic [7:0]               blk_exp_o,
  output logic                     blk_last_o,

  output logic                     byp_valid_o,
  input  logic                     byp_ready_i,
  output logic [DATAW_ALIGN-1:0]   byp_data_o,
  output logic [DATAW_ALIGN/8-1:0] byp_strb_o,

  output logic [CNT_W-1:0]         blk_count_o
);

  localparam int unsigned STRB_W     = DATAW_ALIGN / 8;
  localparam int unsigned BLK_STRB_W = MX_BLOCK_W / 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOW   = 2'd1,
    ST_HIGH  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [DATAW_ALIGN-1:0]   beat_q, beat_d;
  logic                     hi_nz_q, hi_nz_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic                     w_mx_active;
  logic                     w_blk_hs;
  logic                     w_beat_hs;
  logic                     w_beat_done;
  logic                     w_exp_avail;
  logic [7:0]               w_exp_head;
  logic                     w_exp_push;
  logic                     w_exp_pop;

  // Only the low byte of the exponent beat carries information.
  logic                     unused_exp_hi;
  assign unused_exp_hi = ^exp_data_i[DATAW_ALIGN-1:8];

  // A held beat keeps the block path selected until it has fully drained.
  assign w_mx_active = mx_enable_i | (state_q != ST_EMPTY);

  assign blk_valid_o = (state_q != ST_EMPTY) & w_exp_avail;
  assign blk_data_o  = (state_q == ST_HIGH) ? beat_q[DATAW_ALIGN-1:MX_BLOCK_W]
                                            : beat_q[MX_BLOCK_W-1:0];
  assign blk_exp_o   = w_exp_head;
  assign blk_last_o  = (state_q == ST_HIGH) | ((state_q == ST_LOW) & ~hi_nz_q);
  assign blk_count_o = cnt_q;

  assign w_blk_hs    = blk_valid_o & blk_ready_i;
  assign w_beat_done = w_blk_hs & blk_last_o;
  assign w_exp_pop   = w_blk_hs;
  assign w_exp_push  = exp_valid_i & exp_ready_o;

  // Refill on the completing handshake only while MX stays enabled, so a
  // beat arriving after mx_enable_i drops is left for the bypass path.
  assign beat_ready_o = w_mx_active
                      ? ((state_q == ST_EMPTY) | (w_beat_done & mx_enable_i))
                      : byp_ready_i;
  assign w_beat_hs    = w_mx_active & beat_valid_i & beat_ready_o;

  assign byp_valid_o = ~w_mx_active & beat_valid_i;
  assign byp_data_o  = beat_data_i;
  assign byp_strb_o  = beat_strb_i;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    hi_nz_d = hi_nz_q;
    cnt_d   = cnt_q;
    if (w_beat_hs) begin
      state_d = ST_LOW;
      beat_d  = beat_data_i;
      hi_nz_d = |beat_strb_i[STRB_W-1:BLK_STRB_W];
    end else if (w_beat_done) begin
      state_d = ST_EMPTY;
    end else if (w_blk_hs && (state_q == ST_LOW)) begin
      state_d = ST_HIGH;
    end
    if (w_blk_hs) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (clear_i) begin
      state_d = ST_EMPTY;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Held beat contents are meaningless in EMPTY, so they carry no reset.
  always_ff @(posedge clk_i) begin
    beat_q  <= beat_d;
    hi_nz_q <= hi_nz_d;
  end

`ifdef REDMULE_MX_EXP_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [7:0] fifo_d [4];
  logic [1:0] wr_q, wr_d, rd_q, rd_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       w_full;

  assign w_full      = (fcnt_q == 3'd4);
  assign w_exp_avail = (fcnt_q != 3'd0);
  assign w_exp_head  = fifo_q[rd_q];
  assign exp_ready_o = w_mx_active & (~w_full | w_exp_pop);

  always_comb begin
    fifo_d = fifo_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    fcnt_d = fcnt_q + {2'b00, w_exp_push} - {2'b00, w_exp_pop};
    if (w_exp_push) begin
      fifo_d[wr_q] = exp_data_i[7:0];
      wr_d         = wr_q + 2'd1;
    end
    if (w_exp_pop) begin
      rd_d = rd_q + 2'd1;
    end
    if (clear_i) begin
      wr_d   = 2'd0;
      rd_d   = 2'd0;
      fcnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q   <= 2'd0;
      rd_q   <= 2'd0;
      fcnt_q <= 3'd0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fcnt_q <= fcnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
  end
`else
  logic       exp_vld_q, exp_vld_d;
  logic [7:0] exp_q, exp_d;

  assign w_exp_avail = exp_vld_q;
  assign w_exp_head  = exp_q;
  // Same-cycle refill keeps one block per cycle with a single register.
  assign exp_ready_o = w_mx_active & (~exp_vld_q | w_exp_pop);

  always_comb begin
    exp_vld_d = exp_vld_q;
    exp_d     = exp_q;
    if (w_exp_pop) begin
      exp_vld_d = 1'b0;
    end
    if (w_exp_push) begin
      exp_vld_d = 1'b1;
      exp_d     = exp_data_i[7:0];
    end
    if (clear_i) begin
      exp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exp_vld_q <= 1'b0;
    end else begin
      exp_vld_q <= exp_vld_d;
    end
  end

  always_ff @(posedge clk_i) begin
    exp_q <= exp_d;
  end
`endif

endmodule
`default_nettype wire
